// File: rtl/aes_wb_arbiter.sv
// aes_wb_arbiter: round-robin two-master Wishbone arbiter for the AES slave.
// Grant is held for the owner's whole cyc.
// Optional watchdog that terminates stalled accesses: define AES_WB_ARB_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | no owner, slave bus driven to zero
// GRANT0 | master 0 (management core) owns the slave
// GRANT1 | master 1 (LA bridge) owns the slave
module aes_wb_arbiter #(
  parameter int ADDR_W         = 25,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_cyc,
  input  logic              m0_stb,
  input  logic              m0_we,
  input  logic [DATA_W/8-1:0] m0_sel,
  input  logic [ADDR_W-1:0] m0_adr,
  input  logic [DATA_W-1:0] m0_dat_w,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_dat_r,
  input  logic              m1_cyc,
  input  logic              m1_stb,
  input  logic              m1_we,
  input  logic [DATA_W/8-1:0] m1_sel,
  input  logic [ADDR_W-1:0] m1_adr,
  input  logic [DATA_W-1:0] m1_dat_w,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_dat_r,
  output logic              s_cyc,
  output logic              s_stb,
  output logic              s_we,
  output logic [DATA_W/8-1:0] s_sel,
  output logic [ADDR_W-1:0] s_adr,
  output logic [DATA_W-1:0] s_dat_w,
  input  logic              s_ack,
  input  logic [DATA_W-1:0] s_dat_r,
  output logic [1:0]        grant,
  output logic              timeout_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT0 = 2'd1, GRANT1 = 2'd2} state_t;

  state_t state, state_next;
  logic   last, last_next;
  logic   req0, req1;
  logic   wd_fire;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("aes_wb_arbiter: TIMEOUT_CYCLES out of range 1..65535");
  end

  assign req0 = m0_cyc & m0_stb;
  assign req1 = m1_cyc & m1_stb;

  // State register and round-robin pointer; last=1 lets m0 win the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_next;
      last  <= last_next;
    end
  end

  // Next-state: arbitrate in IDLE, hold the owner until its cyc drops.
  always_comb begin
    state_next = state;
    last_next  = last;
    case (state)
      IDLE: begin
        if (req0 && req1) state_next = last ? GRANT0 : GRANT1;
        else if (req0)    state_next = GRANT0;
        else if (req1)    state_next = GRANT1;
      end
      GRANT0: if (!m0_cyc) begin
        state_next = IDLE;
        last_next  = 1'b0;
      end
      GRANT1: if (!m1_cyc) begin
        state_next = IDLE;
        last_next  = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  assign grant = {state == GRANT1, state == GRANT0};

`ifdef AES_WB_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_VAL = TW'(TIMEOUT_CYCLES);
  logic [TW-1:0] wd_cnt;
  logic          own_stb;

  assign own_stb = (state == GRANT0) ? m0_stb : (state == GRANT1) ? m1_stb : 1'b0;
  assign wd_fire = (state != IDLE) && (wd_cnt == TO_VAL);

  // Watchdog: count owner strobe cycles without ack; clear on ack, idle or firing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   wd_cnt <= '0;
    else if (state == IDLE || s_ack || wd_fire)   wd_cnt <= '0;
    else if (own_stb)                             wd_cnt <= wd_cnt + 1'b1;
  end
`else
  assign wd_fire = 1'b0;
`endif

  assign timeout_o = wd_fire;

  // Bus mux: route the owner to the slave, everything zero when idle.
  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_sel    = '0;
    s_adr    = '0;
    s_dat_w  = '0;
    m0_ack   = 1'b0;
    m0_dat_r = '0;
    m1_ack   = 1'b0;
    m1_dat_r = '0;
    case (state)
      GRANT0: begin
        s_cyc    = m0_cyc;
        s_stb    = m0_stb & ~wd_fire;
        s_we     = m0_we;
        s_sel    = m0_sel;
        s_adr    = m0_adr;
        s_dat_w  = m0_dat_w;
        m0_ack   = s_ack | wd_fire;
        m0_dat_r = wd_fire ? DATA_W'(32'hDEAD_BEEF) : s_dat_r;
      end
      GRANT1: begin
        s_cyc    = m1_cyc;
        s_stb    = m1_stb & ~wd_fire;
        s_we     = m1_we;
        s_sel    = m1_sel;
        s_adr    = m1_adr;
        s_dat_w  = m1_dat_w;
        m1_ack   = s_ack | wd_fire;
        m1_dat_r = wd_fire ? DATA_W'(32'hDEAD_BEEF) : s_dat_r;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_aes_wb_arbiter.sv
// Directed bench for aes_wb_arbiter (TIMEOUT_CYCLES=8).
module tb_aes_wb_arbiter;
  localparam int AW = 25;
  localparam int DW = 32;

  logic clk = 1'b0, rst_n = 1'b0;
  logic m0_cyc = 0, m0_stb = 0, m0_we = 0, m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [3:0] m0_sel = '0, m1_sel = '0, s_sel;
  logic [AW-1:0] m0_adr = '0, m1_adr = '0, s_adr;
  logic [DW-1:0] m0_dat_w = '0, m1_dat_w = '0, s_dat_w, m0_dat_r, m1_dat_r;
  logic m0_ack, m1_ack, s_cyc, s_stb, s_we, timeout_o;
  logic s_ack = 0;
  logic [DW-1:0] s_dat_r = '0;
  logic [1:0] grant;

  int vectors = 0;
  int miscompares = 0;

  aes_wb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_sel(m0_sel), .m0_adr(m0_adr),
    .m0_dat_w(m0_dat_w), .m0_ack(m0_ack), .m0_dat_r(m0_dat_r),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_sel(m1_sel), .m1_adr(m1_adr),
    .m1_dat_w(m1_dat_w), .m1_ack(m1_ack), .m1_dat_r(m1_dat_r),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel), .s_adr(s_adr),
    .s_dat_w(s_dat_w), .s_ack(s_ack), .s_dat_r(s_dat_r),
    .grant(grant), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if (grant !== 2'b00 || s_cyc !== 1'b0 || s_stb !== 1'b0 || timeout_o !== 1'b0 ||
        m0_ack !== 1'b0 || m1_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state got grant=%b s_cyc=%b s_stb=%b to=%b ack=%b%b exp all zero",
               grant, s_cyc, s_stb, timeout_o, m0_ack, m1_ack);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    vectors++;
    if (grant !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_idle got %b exp 00", grant);
    end
  endtask

  task automatic test_tie();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    step();
    vectors++;
    if (grant !== 2'b01) begin
      miscompares++;
      $display("FAIL tie_first got %b exp 01", grant);
    end
    m0_cyc = 0; m0_stb = 0;
    step();
    vectors++;
    if (grant !== 2'b00) begin
      miscompares++;
      $display("FAIL tie_gap got %b exp 00", grant);
    end
    step();
    vectors++;
    if (grant !== 2'b10) begin
      miscompares++;
      $display("FAIL tie_second got %b exp 10", grant);
    end
    m1_cyc = 0; m1_stb = 0;
    step();
  endtask

  task automatic test_single();
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_sel = 4'hF;
    m0_adr = 25'h0000010; m0_dat_w = 32'h1234_5678;
    m1_adr = 25'h1ABCDEF; m1_dat_w = 32'hFFFF_0000; m1_sel = 4'h3;
    step();
    vectors++;
    if (grant !== 2'b01 || s_cyc !== 1'b1 || s_stb !== 1'b1 || s_we !== 1'b1) begin
      miscompares++;
      $display("FAIL single_grant got grant=%b cyc=%b stb=%b we=%b exp 01 1 1 1",
               grant, s_cyc, s_stb, s_we);
    end
    vectors++;
    if (s_adr !== 25'h0000010 || s_dat_w !== 32'h1234_5678 || s_sel !== 4'hF) begin
      miscompares++;
      $display("FAIL single_fwd got adr=%h dat=%h sel=%h exp 0000010 12345678 f",
               s_adr, s_dat_w, s_sel);
    end
    vectors++;
    if (m0_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL single_noack_early got %b exp 0", m0_ack);
    end
    step();
    step();
    s_ack = 1; s_dat_r = 32'hCAFE_0001;
    #1;
    vectors++;
    if (m0_ack !== 1'b1 || m1_ack !== 1'b0 || m1_dat_r !== 32'h0) begin
      miscompares++;
      $display("FAIL single_ack got m0_ack=%b m1_ack=%b m1_dat_r=%h exp 1 0 0",
               m0_ack, m1_ack, m1_dat_r);
    end
    step();
    s_ack = 0; s_dat_r = '0; m0_cyc = 0; m0_stb = 0; m0_we = 0;
    #1;
    vectors++;
    if (m0_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL single_ack_once got %b exp 0", m0_ack);
    end
    step();
    vectors++;
    if (grant !== 2'b00 || s_cyc !== 1'b0 || s_adr !== '0) begin
      miscompares++;
      $display("FAIL single_release got grant=%b cyc=%b adr=%h exp 00 0 0", grant, s_cyc, s_adr);
    end
  endtask

  // Entered with last owner = m0 (from test_single), so m1 wins the first tie.
  task automatic test_round_robin();
    logic [1:0] exp_g;
    exp_g = 2'b10;
    for (int i = 0; i < 4; i++) begin
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
      step();
      vectors++;
      if (grant !== exp_g) begin
        miscompares++;
        $display("FAIL rr_round%0d got %b exp %b", i, grant, exp_g);
      end
      m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
      step();
      exp_g = {exp_g[0], exp_g[1]};
    end
  endtask

  task automatic test_locked_burst();
    logic [DW-1:0] d;
    m1_cyc = 1; m1_stb = 1; m1_we = 0;
    step();
    m0_cyc = 1; m0_stb = 1;
    for (int i = 0; i < 4; i++) begin
      s_ack = 0;
      #1;
      vectors++;
      if (grant !== 2'b10 || m0_ack !== 1'b0) begin
        miscompares++;
        $display("FAIL burst_hold%0d got grant=%b m0_ack=%b exp 10 0", i, grant, m0_ack);
      end
      step();
      d = 32'hA500_0000 + DW'(i);
      s_ack = 1; s_dat_r = d;
      #1;
      vectors++;
      if (m1_ack !== 1'b1 || m1_dat_r !== d || m0_ack !== 1'b0 || m0_dat_r !== '0) begin
        miscompares++;
        $display("FAIL burst_read%0d got m1_ack=%b m1_dat_r=%h m0_ack=%b exp 1 %h 0",
                 i, m1_ack, m1_dat_r, m0_ack, d);
      end
      step();
    end
    s_ack = 0; s_dat_r = '0; m1_cyc = 0; m1_stb = 0;
    step();
    vectors++;
    if (grant !== 2'b00) begin
      miscompares++;
      $display("FAIL burst_gap got %b exp 00", grant);
    end
    step();
    vectors++;
    if (grant !== 2'b01) begin
      miscompares++;
      $display("FAIL burst_handover got %b exp 01", grant);
    end
    m0_cyc = 0; m0_stb = 0;
    step();
  endtask

  task automatic test_reset_mid();
    m0_cyc = 1; m0_stb = 1;
    step();
    step();
    #2;
    rst_n = 0;
    #1;
    vectors++;
    if (s_cyc !== 1'b0 || s_stb !== 1'b0 || grant !== 2'b00 || m0_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid got cyc=%b stb=%b grant=%b ack=%b exp 0 0 00 0",
               s_cyc, s_stb, grant, m0_ack);
    end
    m0_cyc = 0; m0_stb = 0;
    @(negedge clk);
    rst_n = 1;
    step();
    vectors++;
    if (grant !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_mid_idle got %b exp 00", grant);
    end
  endtask

  task automatic test_watchdog();
    m0_cyc = 1; m0_stb = 1; s_ack = 0;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k < 9) begin
        vectors++;
        if (m0_ack !== 1'b0 || timeout_o !== 1'b0 || grant !== 2'b01) begin
          miscompares++;
          $display("FAIL wd_wait%0d got ack=%b to=%b grant=%b exp 0 0 01", k, m0_ack, timeout_o, grant);
        end
      end
    end
`ifdef AES_WB_ARB_TIMEOUT_EN
    vectors++;
    if (m0_ack !== 1'b1 || m0_dat_r !== 32'hDEAD_BEEF || timeout_o !== 1'b1 || s_stb !== 1'b0) begin
      miscompares++;
      $display("FAIL wd_fire got ack=%b dat=%h to=%b stb=%b exp 1 deadbeef 1 0",
               m0_ack, m0_dat_r, timeout_o, s_stb);
    end
    step();
    vectors++;
    if (timeout_o !== 1'b0 || m0_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL wd_pulse got to=%b ack=%b exp 0 0", timeout_o, m0_ack);
    end
`else
    vectors++;
    if (m0_ack !== 1'b0 || timeout_o !== 1'b0 || s_stb !== 1'b1) begin
      miscompares++;
      $display("FAIL wd_absent got ack=%b to=%b stb=%b exp 0 0 1", m0_ack, timeout_o, s_stb);
    end
`endif
    m0_cyc = 0; m0_stb = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_tie();
    test_single();
    test_round_robin();
    test_locked_burst();
    test_reset_mid();
    test_watchdog();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
